// File: rtl/twiddle_phase_gen_pkg.sv
// twiddle_phase_gen_pkg: shared phase constants and twiddle index map
package twiddle_phase_gen_pkg;
  localparam int PHASE_W = 8;
  localparam logic [PHASE_W-1:0] QUARTER_TURN = 8'd64;
  // Phase index of the twiddle for position p once inside the difference window
  function automatic logic [PHASE_W-1:0] tw_idx(input logic [7:0] p, input int n_log2, input int stage);
    return 8'((int'(p) & ((1 << (n_log2 - stage - 1)) - 1)) << (stage + 8 - n_log2));
  endfunction
endpackage

// File: rtl/twiddle_phase_gen_if.sv
// twiddle_phase_gen_if: sample handshake in, phase words out
interface twiddle_phase_gen_if;
  import twiddle_phase_gen_pkg::*;
  logic sync;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic [PHASE_W-1:0] phi_re;
  logic [PHASE_W-1:0] phi_im;
  logic twiddle_en;
  logic frame_last;
  modport master(output sync, in_valid, out_ready, input in_ready, out_valid, phi_re, phi_im, twiddle_en, frame_last);
  modport slave(input sync, in_valid, out_ready, output in_ready, out_valid, phi_re, phi_im, twiddle_en, frame_last);
endinterface

// File: rtl/twiddle_phase_gen.sv
// twiddle_phase_gen: per-sample LUT phase words and twiddle window for one SDF stage
module twiddle_phase_gen #(
  parameter int N_LOG2 = 8,
  parameter int STAGE = 0,
  parameter int PHASE_W = 8
) (
  input logic clk,
  input logic rst,
  twiddle_phase_gen_if.slave bus
);
  import twiddle_phase_gen_pkg::QUARTER_TURN;
  import twiddle_phase_gen_pkg::tw_idx;
  logic [N_LOG2-1:0] cnt, p;
  logic [PHASE_W-1:0] idx;
  logic accept, w;
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept = bus.in_valid && bus.in_ready;
  assign p = bus.sync ? '0 : cnt;
  // Upper half of each stride-L block is the difference branch
  assign w = p[N_LOG2-1-STAGE];
  assign idx = tw_idx(8'(p), N_LOG2, STAGE);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      bus.out_valid <= 1'b0;
      bus.phi_re <= QUARTER_TURN;
      bus.phi_im <= '0;
      bus.twiddle_en <= 1'b0;
      bus.frame_last <= 1'b0;
    end else begin
      bus.out_valid <= accept || (bus.out_valid && !bus.out_ready);
      if (accept) begin
        cnt <= p + 1'b1;
        bus.phi_re <= w ? idx + QUARTER_TURN : QUARTER_TURN;
        bus.phi_im <= w ? -idx : '0;
        bus.twiddle_en <= w;
        bus.frame_last <= &p;
      end
    end
endmodule

// File: tb/tb_twiddle_phase_gen.sv
// tb_twiddle_phase_gen: table vectors, corner sequences and random traffic vs a phase model
module tb_twiddle_phase_gen;
  localparam int NI = 4;
  localparam int NL [NI] = '{3, 3, 3, 8};
  localparam int ST [NI] = '{0, 1, 2, 0};
  logic clk = 0, rst = 0, sync = 0, in_valid = 0, out_ready = 1;
  logic [NI-1:0] ov, ir, ten, fl;
  logic [NI-1:0][7:0] pre, pim;
  int checks = 0, errors = 0;
  int cnt_m [NI];
  logic v_m = 0;
  logic [7:0] re_m [NI], im_m [NI];
  logic te_m [NI], fl_m [NI];
  typedef struct {
    logic [7:0] re0, im0;
    logic te0, fl0;
    logic [7:0] re1, im1;
    logic te1;
  } vec_t;
  vec_t tv [8];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : u
    twiddle_phase_gen_if bus();
    assign bus.sync = sync;
    assign bus.in_valid = in_valid;
    assign bus.out_ready = out_ready;
    assign ov[g] = bus.out_valid;
    assign ir[g] = bus.in_ready;
    assign ten[g] = bus.twiddle_en;
    assign fl[g] = bus.frame_last;
    assign pre[g] = bus.phi_re;
    assign pim[g] = bus.phi_im;
    twiddle_phase_gen #(.N_LOG2(NL[g]), .STAGE(ST[g]), .PHASE_W(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  end

  task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, g, act, exp, $time);
    end
  endtask

  // Twiddle W = exp(-j*2*pi*k/N) as an angle on a 256-step circle
  function automatic void ref_map(input int n, input int s, input int p, output logic [7:0] re, output logic [7:0] im, output logic te, output logic f);
    int l, h, q, idx;
    l = (1 << n) >> s;
    h = l / 2;
    q = p % l;
    te = q >= h;
    idx = te ? ((q - h) * (1 << s) * 256) / (1 << n) : 0;
    re = 8'((idx + 64) % 256);
    im = 8'((256 - idx) % 256);
    f = p == (1 << n) - 1;
  endfunction

  task automatic step(input logic s, input logic v, input logic r);
    logic ir_e, acc;
    int p;
    sync = s;
    in_valid = v;
    out_ready = r;
    ir_e = !v_m || r;
    #1;
    for (int g = 0; g < NI; g++) chk("in_ready", g, 32'(ir[g]), 32'(ir_e));
    @(posedge clk);
    acc = v && ir_e;
    if (acc)
      for (int g = 0; g < NI; g++) begin
        p = s ? 0 : cnt_m[g];
        ref_map(NL[g], ST[g], p, re_m[g], im_m[g], te_m[g], fl_m[g]);
        cnt_m[g] = (p + 1) % (1 << NL[g]);
      end
    v_m = acc || (v_m && !r);
    #1;
    for (int g = 0; g < NI; g++) begin
      chk("out_valid", g, 32'(ov[g]), 32'(v_m));
      if (v_m) begin
        chk("phi_re", g, 32'(pre[g]), 32'(re_m[g]));
        chk("phi_im", g, 32'(pim[g]), 32'(im_m[g]));
        chk("twiddle_en", g, 32'(ten[g]), 32'(te_m[g]));
        chk("frame_last", g, 32'(fl[g]), 32'(fl_m[g]));
      end
    end
    @(negedge clk);
  endtask

  task automatic async_reset();
    #2 rst = 1;
    #1;
    for (int g = 0; g < NI; g++) begin
      chk("rst_out_valid", g, 32'(ov[g]), 0);
      chk("rst_phi_re", g, 32'(pre[g]), 32'h40);
      chk("rst_phi_im", g, 32'(pim[g]), 0);
      chk("rst_twiddle_en", g, 32'(ten[g]), 0);
      chk("rst_frame_last", g, 32'(fl[g]), 0);
      cnt_m[g] = 0;
    end
    v_m = 0;
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    tv[0] = '{8'h40, 8'h00, 1'b0, 1'b0, 8'h40, 8'h00, 1'b0};
    tv[1] = '{8'h40, 8'h00, 1'b0, 1'b0, 8'h40, 8'h00, 1'b0};
    tv[2] = '{8'h40, 8'h00, 1'b0, 1'b0, 8'h40, 8'h00, 1'b1};
    tv[3] = '{8'h40, 8'h00, 1'b0, 1'b0, 8'h80, 8'hC0, 1'b1};
    tv[4] = '{8'h40, 8'h00, 1'b1, 1'b0, 8'h40, 8'h00, 1'b0};
    tv[5] = '{8'h60, 8'hE0, 1'b1, 1'b0, 8'h40, 8'h00, 1'b0};
    tv[6] = '{8'h80, 8'hC0, 1'b1, 1'b0, 8'h40, 8'h00, 1'b1};
    tv[7] = '{8'hA0, 8'hA0, 1'b1, 1'b1, 8'h80, 8'hC0, 1'b1};
    @(negedge clk);
    async_reset();
    // T1/T2: one back-to-back frame against the table
    for (int i = 0; i < 8; i++) begin
      step(i == 0, 1, 1);
      chk("t1_phi_re", 0, 32'(pre[0]), 32'(tv[i].re0));
      chk("t1_phi_im", 0, 32'(pim[0]), 32'(tv[i].im0));
      chk("t1_twiddle_en", 0, 32'(ten[0]), 32'(tv[i].te0));
      chk("t1_frame_last", 0, 32'(fl[0]), 32'(tv[i].fl0));
      chk("t2_phi_re", 1, 32'(pre[1]), 32'(tv[i].re1));
      chk("t2_phi_im", 1, 32'(pim[1]), 32'(tv[i].im1));
      chk("t2_twiddle_en", 1, 32'(ten[1]), 32'(tv[i].te1));
      chk("last_stage_en", 2, 32'(ten[2]), 32'(i % 2));
    end
    // T3: stall at p5, then p6 must follow
    for (int i = 0; i < 6; i++) step(i == 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0);
      chk("t3_hold_re", 0, 32'(pre[0]), 32'h60);
      chk("t3_in_ready", 0, 32'(ir[0]), 0);
    end
    step(0, 1, 1);
    chk("t3_next_re", 0, 32'(pre[0]), 32'h80);
    step(0, 0, 1);
    // T4: sync on the p5 accept restarts the frame
    for (int i = 0; i < 5; i++) step(i == 0, 1, 1);
    step(1, 1, 1);
    chk("t4_sync_en", 0, 32'(ten[0]), 0);
    for (int i = 1; i < 8; i++) begin
      step(0, 1, 1);
      chk("t4_frame_last", 0, 32'(fl[0]), 32'(i == 7));
    end
    // T5: async reset mid-frame at p3
    for (int i = 0; i < 4; i++) step(i == 0, 1, 1);
    async_reset();
    step(0, 1, 1);
    chk("t5_first_p0_en", 0, 32'(ten[0]), 0);
    chk("t5_first_p0_fl", 0, 32'(fl[0]), 0);
    // T6: full 256-point frame and wrap
    for (int i = 0; i < 256; i++) step(i == 0, 1, 1);
    chk("t6_p255_re", 3, 32'(pre[3]), 32'hBF);
    chk("t6_p255_im", 3, 32'(pim[3]), 32'h81);
    chk("t6_p255_fl", 3, 32'(fl[3]), 1);
    step(0, 1, 1);
    chk("t6_wrap_en", 3, 32'(ten[3]), 0);
    chk("t6_wrap_fl", 3, 32'(fl[3]), 0);
    // Random traffic, including sync on stalled cycles
    for (int i = 0; i < 400; i++)
      step($urandom_range(9) == 0, $urandom_range(9) < 7, $urandom_range(9) < 7);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
